// File: rtl/spi_dump_pkg.sv
// Shared opcodes, FSM encoding, command field layout and CRC-16-CCITT helper
// for the SPI capture/replay buffer.
package spi_dump_pkg;

   // Opcode occupies the top OPC_W bits of a command word; the count fills the rest.
   localparam int unsigned OPC_W = 4;

   localparam logic [OPC_W-1:0] OP_NOP    = 4'd0;
   localparam logic [OPC_W-1:0] OP_CLEAR  = 4'd1;
   localparam logic [OPC_W-1:0] OP_RECORD = 4'd2;
   localparam logic [OPC_W-1:0] OP_DUMP   = 4'd3;
   localparam logic [OPC_W-1:0] OP_STATUS = 4'd4;
   localparam logic [OPC_W-1:0] OP_LOOP   = 4'd5;
   localparam logic [OPC_W-1:0] OP_CRC    = 4'd6;

   typedef enum logic [1:0] {
      S_CMD  = 2'd0,
      S_REC  = 2'd1,
      S_DUMP = 2'd2,
      S_LOOP = 2'd3
   } state_t;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   // MSB-first CRC-16-CCITT update over one 16-bit word.
   function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [15:0] d);
      logic [15:0] c;
      c = crc;
      for (int i = 15; i >= 0; i--) begin
         if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
         else              c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/spi_dump_ram.sv
// Simple dual-port RAM with registered read; a same-address write/read returns old data.
module spi_dump_ram #(
   parameter int unsigned WORD_W = 16,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/spi_dump_buffer.sv
// Command-driven capture/replay buffer between the spi_slave word handshake and a RAM.
// Optional CRC-16 of recorded words (opcode 6) is built when SPI_DUMP_CRC_EN is defined.
module spi_dump_buffer
   import spi_dump_pkg::*;
#(
   parameter int unsigned WORD_W     = 16,
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned LOOP_DELAY = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rd_data_available,
   input  logic [WORD_W-1:0] rd_data,
   output logic              rd_ack,
   input  logic              wr_buffer_free,
   output logic              wr_en,
   output logic [WORD_W-1:0] wr_data,
   output logic              overflow,
   output logic              underflow,
   output logic              busy
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned FILL_W = ADDR_W + 1;
   localparam int unsigned CNT_W  = WORD_W - OPC_W;

   state_t            state, state_n;
   logic [CNT_W-1:0]  remaining, rem_n;
   logic [ADDR_W-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
   logic [FILL_W-1:0] fill, fill_n;
   logic              ovf_n, unf_n;

   logic              avail_q, edge_hold, pending, proc_v;
   logic [WORD_W-1:0] word_q;
   logic              rep_v_q, rep_ram_q, rep_ram_n, reply_rdy;
   logic [WORD_W-1:0] rep_val_q, rep_val_n, reply_q;

   logic              ram_we_c;
   logic [ADDR_W-1:0] ram_waddr_c, ram_raddr_c;
   logic [WORD_W-1:0] ram_wdata_c, ram_rdata;

   logic              edge_c, take_c, wr_fire_c, last_c;
   logic [OPC_W-1:0]  opcode_c;
   logic [CNT_W-1:0]  count_c;

`ifdef SPI_DUMP_CRC_EN
   logic [15:0] crc, crc_n;
`endif

   assign edge_c    = rd_data_available & ~avail_q;
   assign take_c    = (edge_c | edge_hold) & ~pending;
   assign wr_fire_c = reply_rdy & wr_buffer_free;
   assign opcode_c  = word_q[WORD_W-1 -: OPC_W];
   assign count_c   = word_q[CNT_W-1:0];
   assign last_c    = (remaining == CNT_W'(1));

   spi_dump_ram #(.WORD_W(WORD_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .we    (ram_we_c),
      .waddr (ram_waddr_c),
      .wdata (ram_wdata_c),
      .raddr (ram_raddr_c),
      .rdata (ram_rdata)
   );

   // Intake edge detection and the one-word-in-flight reply pipeline.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         avail_q   <= 1'b0;
         edge_hold <= 1'b0;
         pending   <= 1'b0;
         proc_v    <= 1'b0;
         word_q    <= '0;
         rd_ack    <= 1'b0;
         rep_v_q   <= 1'b0;
         rep_ram_q <= 1'b0;
         rep_val_q <= '0;
         reply_q   <= '0;
         reply_rdy <= 1'b0;
         wr_en     <= 1'b0;
         wr_data   <= '0;
      end else begin
         avail_q   <= rd_data_available;
         edge_hold <= take_c ? 1'b0 : (edge_hold | edge_c);
         rd_ack    <= take_c;
         proc_v    <= take_c;
         if (take_c) word_q <= rd_data;
         if (take_c)         pending <= 1'b1;
         else if (wr_fire_c) pending <= 1'b0;
         rep_v_q   <= proc_v;
         rep_ram_q <= rep_ram_n;
         rep_val_q <= rep_val_n;
         if (rep_v_q) begin
            reply_q   <= rep_ram_q ? ram_rdata : rep_val_q;
            reply_rdy <= 1'b1;
         end else if (wr_fire_c) begin
            reply_rdy <= 1'b0;
         end
         wr_en <= wr_fire_c;
         if (wr_fire_c) wr_data <= reply_q;
      end
   end

   // FSM and buffer bookkeeping register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= S_CMD;
         remaining <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fill      <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         busy      <= 1'b0;
`ifdef SPI_DUMP_CRC_EN
         crc       <= CRC_INIT;
`endif
      end else begin
         state     <= state_n;
         remaining <= rem_n;
         wr_ptr    <= wr_ptr_n;
         rd_ptr    <= rd_ptr_n;
         fill      <= fill_n;
         overflow  <= ovf_n;
         underflow <= unf_n;
         busy      <= (state_n != S_CMD);
`ifdef SPI_DUMP_CRC_EN
         crc       <= crc_n;
`endif
      end
   end

   // Word processing: next state, RAM access and reply selection.
   always_comb begin
      state_n     = state;
      rem_n       = remaining;
      wr_ptr_n    = wr_ptr;
      rd_ptr_n    = rd_ptr;
      fill_n      = fill;
      ovf_n       = overflow;
      unf_n       = underflow;
      ram_we_c    = 1'b0;
      ram_waddr_c = wr_ptr;
      ram_wdata_c = word_q;
      ram_raddr_c = rd_ptr;
      rep_ram_n   = 1'b0;
      rep_val_n   = '0;
`ifdef SPI_DUMP_CRC_EN
      crc_n       = crc;
`endif
      if (proc_v) begin
         case (state)
            S_CMD: begin
               rep_val_n = WORD_W'(fill);
               case (opcode_c)
                  OP_CLEAR: begin
                     wr_ptr_n = '0;
                     rd_ptr_n = '0;
                     fill_n   = '0;
                     ovf_n    = 1'b0;
                     unf_n    = 1'b0;
`ifdef SPI_DUMP_CRC_EN
                     crc_n    = CRC_INIT;
`endif
                  end
                  OP_RECORD: if (count_c != '0) begin
                     state_n = S_REC;
                     rem_n   = count_c;
                  end
                  OP_DUMP: if (count_c != '0) begin
                     state_n = S_DUMP;
                     rem_n   = count_c;
                  end
                  OP_LOOP: begin
                     wr_ptr_n = '0;
                     rd_ptr_n = '0;
                     fill_n   = '0;
                     if (count_c != '0) begin
                        state_n = S_LOOP;
                        rem_n   = count_c;
                     end
                  end
`ifdef SPI_DUMP_CRC_EN
                  OP_CRC: rep_val_n = WORD_W'(crc);
`endif
                  default: ;
               endcase
            end
            S_REC: begin
               rem_n = remaining - CNT_W'(1);
               if (last_c) state_n = S_CMD;
               if (fill == FILL_W'(DEPTH)) begin
                  ovf_n = 1'b1;
               end else begin
                  ram_we_c = 1'b1;
                  wr_ptr_n = wr_ptr + ADDR_W'(1);
                  fill_n   = fill + FILL_W'(1);
`ifdef SPI_DUMP_CRC_EN
                  crc_n    = crc16_upd(crc, 16'(word_q));
`endif
               end
            end
            S_DUMP: begin
               rem_n = remaining - CNT_W'(1);
               if (last_c) state_n = S_CMD;
               if (fill == '0) begin
                  unf_n = 1'b1;
               end else begin
                  rep_ram_n = 1'b1;
                  rd_ptr_n  = rd_ptr + ADDR_W'(1);
                  fill_n    = fill - FILL_W'(1);
               end
            end
            S_LOOP: begin
               // fill counts words up to LOOP_DELAY; once saturated the delayed word is replayed
               rem_n       = remaining - CNT_W'(1);
               ram_we_c    = 1'b1;
               ram_raddr_c = wr_ptr - ADDR_W'(LOOP_DELAY);
               wr_ptr_n    = wr_ptr + ADDR_W'(1);
               if (fill == FILL_W'(LOOP_DELAY)) rep_ram_n = 1'b1;
               else                            fill_n    = fill + FILL_W'(1);
               if (last_c) begin
                  state_n  = S_CMD;
                  wr_ptr_n = '0;
                  rd_ptr_n = '0;
                  fill_n   = '0;
               end
            end
            default: state_n = S_CMD;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_dump_buffer.sv
// Scoreboard bench for spi_dump_buffer (DEPTH=16, LOOP_DELAY=8): expected replies are
// queued at stimulus time and popped by a monitor on every wr_en.
module tb_spi_dump_buffer;

   localparam int unsigned WORD_W     = 16;
   localparam int unsigned DEPTH      = 16;
   localparam int unsigned LOOP_DELAY = 8;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              rd_data_available;
   logic [WORD_W-1:0] rd_data;
   logic              rd_ack;
   logic              wr_buffer_free;
   logic              wr_en;
   logic [WORD_W-1:0] wr_data;
   logic              overflow;
   logic              underflow;
   logic              busy;

   int checks   = 0;
   int failures = 0;
   logic [WORD_W-1:0] exp_q[$];

   spi_dump_buffer #(.WORD_W(WORD_W), .DEPTH(DEPTH), .LOOP_DELAY(LOOP_DELAY)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .rd_data_available (rd_data_available),
      .rd_data           (rd_data),
      .rd_ack            (rd_ack),
      .wr_buffer_free    (wr_buffer_free),
      .wr_en             (wr_en),
      .wr_data           (wr_data),
      .overflow          (overflow),
      .underflow         (underflow),
      .busy              (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] crc_model(input logic [15:0] init, input logic [15:0] d);
      logic [15:0] c;
      logic        msb;
      c = init;
      for (int i = 0; i < 16; i++) begin
         msb = c[15] ^ d[15-i];
         c   = c << 1;
         if (msb) c = c ^ 16'h1021;
      end
      return c;
   endfunction

   // Monitor: every reply write is compared against the oldest queued expectation.
   always @(negedge clk) begin
      if (reset_n && wr_en) begin
         if (exp_q.size() == 0) check("unexpected_reply", 32'(wr_data), 32'hDEAD_BEEF);
         else                   check("reply", 32'(wr_data), 32'(exp_q.pop_front()));
      end
   end

   task automatic send_word(input logic [WORD_W-1:0] w, input logic [WORD_W-1:0] exp);
      bit got = 0;
      exp_q.push_back(exp);
      rd_data           = w;
      rd_data_available = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (rd_ack) begin
            got = 1;
            break;
         end
      end
      if (!got) check("rd_ack_timeout", 32'(w), 32'hFFFF_FFFF);
      rd_data_available = 1'b0;
      @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n           = 1'b0;
      rd_data_available = 1'b0;
      rd_data           = '0;
      wr_buffer_free    = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_rd_ack", 32'(rd_ack), 32'd0);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_underflow", 32'(underflow), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // RECORD 3, STATUS, DUMP 3
      send_word(16'h2003, 16'h0000);
      check("busy_in_rec", 32'(busy), 32'd1);
      send_word(16'h1234, 16'h0000);
      send_word(16'h5678, 16'h0000);
      send_word(16'h9ABC, 16'h0000);
      send_word(16'h4000, 16'h0003);
      send_word(16'h3003, 16'h0003);
      send_word(16'h0000, 16'h1234);
      send_word(16'h0000, 16'h5678);
      send_word(16'h0000, 16'h9ABC);
      send_word(16'h4000, 16'h0000);
      drain();
      check("busy_idle", 32'(busy), 32'd0);

      // Overflow: RECORD 18 into a 16-deep buffer, then DUMP 17
      send_word(16'h1000, 16'h0000);
      send_word(16'h2012, 16'h0000);
      for (int i = 1; i <= 16; i++) send_word(16'(16'h0100 + i), 16'h0000);
      drain();
      check("no_overflow_at_full", 32'(overflow), 32'd0);
      send_word(16'h0111, 16'h0000);
      drain();
      check("overflow_set", 32'(overflow), 32'd1);
      send_word(16'h0112, 16'h0000);
      send_word(16'h4000, 16'h0010);
      send_word(16'h3011, 16'h0010);
      for (int i = 1; i <= 16; i++) send_word(16'h0000, 16'(16'h0100 + i));
      drain();
      check("no_underflow_yet", 32'(underflow), 32'd0);
      send_word(16'h0000, 16'h0000);
      drain();
      check("underflow_set", 32'(underflow), 32'd1);

      // LOOP 12, payload 1..12
      send_word(16'h500C, 16'h0000);
      for (int k = 1; k <= 12; k++)
         send_word(16'(k), (k <= int'(LOOP_DELAY)) ? 16'h0000 : 16'(k - int'(LOOP_DELAY)));
      send_word(16'h4000, 16'h0000);
      drain();
      check("busy_after_loop", 32'(busy), 32'd0);

      // Back-pressure: held reply blocks intake of the next word
      send_word(16'h2002, 16'h0000);
      send_word(16'h0AAA, 16'h0000);
      drain();
      wr_buffer_free = 1'b0;
      send_word(16'h0BBB, 16'h0000);
      fork
         begin
            int seen_wr  = 0;
            int seen_ack = 0;
            repeat (20) begin
               @(negedge clk);
               if (wr_en)  seen_wr++;
               if (rd_ack) seen_ack++;
            end
            check("hold_no_wr_en", 32'(seen_wr), 32'd0);
            check("hold_no_rd_ack", 32'(seen_ack), 32'd0);
            wr_buffer_free = 1'b1;
         end
         send_word(16'h4000, 16'h0002);
      join
      drain();

      // CRC of a single zero word (or fill count without the CRC build)
      send_word(16'h1000, 16'h0002);
      send_word(16'h2001, 16'h0000);
      send_word(16'h0000, 16'h0000);
`ifdef SPI_DUMP_CRC_EN
      send_word(16'h6000, crc_model(16'hFFFF, 16'h0000));
`else
      send_word(16'h6000, 16'h0001);
`endif
      drain();

      // Reset mid-DUMP with underflow set
      send_word(16'h1000, 16'h0001);
      send_word(16'h3002, 16'h0000);
      send_word(16'h0000, 16'h0000);
      drain();
      check("pre_rst_busy", 32'(busy), 32'd1);
      check("pre_rst_underflow", 32'(underflow), 32'd1);
      reset_n = 1'b0;
      @(negedge clk);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_wr_en", 32'(wr_en), 32'd0);
      check("mid_rst_underflow", 32'(underflow), 32'd0);
      check("mid_rst_overflow", 32'(overflow), 32'd0);
      exp_q.delete();
      reset_n = 1'b1;
      @(negedge clk);
      send_word(16'h4000, 16'h0000);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
